// File: rtl/serial_addsub_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
// The parameter check is a function so any wrapper can reuse the same rule.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int num_steps(input int width, input int digit);
        return width / digit;
    endfunction

    // A one-step configuration still needs a 1-bit counter to exist.
    function automatic int cnt_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

    function automatic bit params_ok(input int width, input int digit);
        return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Start/done handshake, operands and result/status bundle for serial_addsub.
// The master drives the request side; the slave (the adder) drives status.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             ci;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport master (
        output start, sub, ci, a, b,
        input  busy, done, result, cout, overflow, zero, negative
    );

    modport slave (
        input  start, sub, ci, a, b,
        output busy, done, result, cout, overflow, zero, negative
    );
endinterface

// File: rtl/serial_addsub_digit_adder.sv
// Combinational DIGIT-bit ripple slice built from the single-bit full-adder cell.
// This is the only arithmetic in the datapath; it is reused every step.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic             cin,
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);
    logic [DIGIT:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        full_adder u_fa (
            .a_i  (x[i]),
            .b_i  (y[i]),
            .ci_i (carry[i]),
            .s_o  (sum[i]),
            .co_o (carry[i+1])
        );
    end

    assign cout = carry[DIGIT];
endmodule

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract: DIGIT bits per clock, LSB first, through one shared slice.
// Result and flags are registered on entry to DONE and held until the next completion.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic           clk,
    input  logic           reset,
    serial_addsub_if.slave bus
);

    localparam int               N         = num_steps(WIDTH, DIGIT);
    localparam int               CNT_W     = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

    if (!params_ok(WIDTH, DIGIT)) begin : g_param_check
        $error("serial_addsub: WIDTH must be >= 2 and an integer multiple of DIGIT");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;

    logic [DIGIT-1:0]       slice_sum;
    logic                   slice_cout;
    logic [WIDTH+DIGIT-1:0] acc_cat;
    logic [WIDTH-1:0]       acc_next;
    logic [WIDTH-1:0]       beff;

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_slice (
        .cin  (carry_q),
        .x    (a_q[DIGIT-1:0]),
        .y    (b_q[DIGIT-1:0]),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Each new slice enters at the top, so after N steps the LSB slice sits at bit 0.
    assign acc_cat  = {slice_sum, acc_q};
    assign acc_next = acc_cat[WIDTH+DIGIT-1:DIGIT];
    assign beff     = bus.sub ? ~bus.b : bus.b;

    always_comb begin
        // NOTE: every _d signal takes its hold value first, so no branch can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        neg_d    = neg_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    a_d     = bus.a;
                    b_d     = beff;
                    carry_d = bus.ci ^ bus.sub;
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = beff[WIDTH-1];
                    acc_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = slice_cout;
                acc_d   = acc_next;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d  = DONE;
                    result_d = acc_next;
                    cout_d   = slice_cout;
                    ovf_d    = (a_msb_q == b_msb_q) && (acc_next[WIDTH-1] != a_msb_q);
                    zero_d   = (acc_next == '0);
                    neg_d    = acc_next[WIDTH-1];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking updates, so every register samples the pre-edge values.
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;
    assign bus.negative = neg_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub in 8/1, 16/4 and 16/16 configurations.
// Expected results come from a reference arithmetic model through a scoreboard queue.
module tb_serial_addsub;

    typedef struct packed {
        logic [15:0] result;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } res_t;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    res_t sb_q[$];

    serial_addsub_if #(.WIDTH(8))  b8  ();
    serial_addsub_if #(.WIDTH(16)) b16 ();
    serial_addsub_if #(.WIDTH(16)) b16w ();

    serial_addsub #(.WIDTH(8),  .DIGIT(1))  u_d8    (.clk(clk), .reset(reset), .bus(b8));
    serial_addsub #(.WIDTH(16), .DIGIT(4))  u_d16   (.clk(clk), .reset(reset), .bus(b16));
    serial_addsub #(.WIDTH(16), .DIGIT(16)) u_d16w  (.clk(clk), .reset(reset), .bus(b16w));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic res_t model(input int w, input bit sb, input bit c,
                                   input logic [15:0] av, input logic [15:0] bv);
        logic [16:0] mask;
        logic [16:0] be;
        logic [16:0] s;
        res_t        r;
        mask     = (17'd1 << w) - 17'd1;
        be       = (sb ? ~{1'b0, bv} : {1'b0, bv}) & mask;
        s        = {1'b0, av} + be + {16'd0, c ^ sb};
        r.result = s[15:0] & mask[15:0];
        r.cout   = s[w];
        r.neg    = r.result[w-1];
        r.zero   = (r.result == 16'd0);
        r.ovf    = (av[w-1] == be[w-1]) && (r.result[w-1] != av[w-1]);
        return r;
    endfunction

    function automatic int width_of(input int d);
        return (d == 0) ? 8 : 16;
    endfunction

    function automatic int steps_of(input int d);
        case (d)
            0:       return 8;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic res_t obs(input int d);
        res_t r;
        case (d)
            0:       r = '{{8'd0, b8.result}, b8.cout, b8.overflow, b8.zero, b8.negative};
            1:       r = '{b16.result, b16.cout, b16.overflow, b16.zero, b16.negative};
            default: r = '{b16w.result, b16w.cout, b16w.overflow, b16w.zero, b16w.negative};
        endcase
        return r;
    endfunction

    function automatic logic busy_of(input int d);
        case (d)
            0:       return b8.busy;
            1:       return b16.busy;
            default: return b16w.busy;
        endcase
    endfunction

    function automatic logic done_of(input int d);
        case (d)
            0:       return b8.done;
            1:       return b16.done;
            default: return b16w.done;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input bit s, input bit sb, input bit c,
                         input logic [15:0] av, input logic [15:0] bv);
        case (d)
            0: begin
                b8.start = s; b8.sub = sb; b8.ci = c; b8.a = av[7:0]; b8.b = bv[7:0];
            end
            1: begin
                b16.start = s; b16.sub = sb; b16.ci = c; b16.a = av; b16.b = bv;
            end
            default: begin
                b16w.start = s; b16w.sub = sb; b16w.ci = c; b16w.a = av; b16w.b = bv;
            end
        endcase
    endtask

    // Counts edges until done, starting just after the edge that sampled start.
    task automatic wait_done(input int d, input int exp_lat);
        int cyc;
        cyc = 0;
        while (!done_of(d) && cyc < 64) begin
            tick();
            cyc++;
        end
        check("latency", cyc, exp_lat);
    endtask

    task automatic check_out(input int d);
        res_t e;
        res_t o;
        check("done", done_of(d), 1'b1);
        check("sb_depth", sb_q.size() > 0, 1'b1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = obs(d);
            check("result", o.result, e.result);
            check("cout", o.cout, e.cout);
            check("overflow", o.ovf, e.ovf);
            check("zero", o.zero, e.zero);
            check("negative", o.neg, e.neg);
        end
    endtask

    task automatic run_op(input int d, input bit sb, input bit c,
                          input logic [15:0] av, input logic [15:0] bv);
        sb_q.push_back(model(width_of(d), sb, c, av, bv));
        drive(d, 1'b1, sb, c, av, bv);
        tick();
        check("busy_after_start", busy_of(d), 1'b1);
        drive(d, 1'b0, sb, c, av, bv);
        wait_done(d, steps_of(d));
        check_out(d);
        tick();
    endtask

    task automatic check_cleared(input int d);
        check("rst_busy", busy_of(d), 1'b0);
        check("rst_done", done_of(d), 1'b0);
        check("rst_flags", obs(d), '0);
    endtask

    initial begin
        res_t held;
        tests = 0;
        fails = 0;
        reset = 1'b1;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        tick();
        tick();
        reset = 1'b0;
        for (int d = 0; d < 3; d++) check_cleared(d);

        // 8-bit bit-serial arithmetic and flag cases
        run_op(0, 1'b1, 1'b0, 16'h05, 16'h03);
        run_op(0, 1'b1, 1'b0, 16'h03, 16'h05);
        run_op(0, 1'b1, 1'b0, 16'h05, 16'h05);
        run_op(0, 1'b0, 1'b0, 16'h7F, 16'h01);
        run_op(0, 1'b1, 1'b0, 16'h80, 16'h01);
        run_op(0, 1'b0, 1'b1, 16'hFF, 16'h00);
        run_op(0, 1'b1, 1'b1, 16'h10, 16'h01);

        // start and operand changes while busy are ignored
        sb_q.push_back(model(8, 1'b0, 1'b0, 16'h20, 16'h10));
        drive(0, 1'b1, 1'b0, 1'b0, 16'h20, 16'h10);
        tick();
        drive(0, 1'b0, 1'b0, 1'b0, 16'h20, 16'h10);
        tick();
        tick();
        drive(0, 1'b1, 1'b1, 1'b1, 16'h55, 16'h11);
        tick();
        tick();
        drive(0, 1'b0, 1'b1, 1'b1, 16'h55, 16'h11);
        wait_done(0, 4);
        check_out(0);
        tick();

        // back-to-back: start held in the DONE cycle
        held = model(8, 1'b1, 1'b0, 16'h33, 16'h11);
        sb_q.push_back(held);
        drive(0, 1'b1, 1'b1, 1'b0, 16'h33, 16'h11);
        tick();
        drive(0, 1'b0, 1'b1, 1'b0, 16'h33, 16'h11);
        wait_done(0, 8);
        check_out(0);
        sb_q.push_back(model(8, 1'b0, 1'b0, 16'h12, 16'h34));
        drive(0, 1'b1, 1'b0, 1'b0, 16'h12, 16'h34);
        tick();
        check("b2b_busy", busy_of(0), 1'b1);
        check("b2b_done", done_of(0), 1'b0);
        check("hold_in_run", obs(0), held);
        drive(0, 1'b0, 1'b0, 1'b0, 16'h12, 16'h34);
        wait_done(0, 8);
        check_out(0);
        tick();

        // reset on the third RUN cycle aborts with everything cleared
        drive(0, 1'b1, 1'b0, 1'b0, 16'h40, 16'h01);
        tick();
        drive(0, 1'b0, 1'b0, 1'b0, 16'h40, 16'h01);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_cleared(0);
        check("sb_idle", sb_q.size(), 0);
        run_op(0, 1'b1, 1'b0, 16'd10, 16'd4);

        // wider configurations: 4-bit digits and a single full-width step
        run_op(1, 1'b1, 1'b0, 16'h1000, 16'h0001);
        run_op(1, 1'b0, 1'b0, 16'h7FFF, 16'h0001);
        run_op(2, 1'b1, 1'b0, 16'h1000, 16'h0001);
        run_op(2, 1'b0, 1'b1, 16'hFFFF, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
